// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct constants and datapath mux select encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef enum logic [1:0] {
    SRCB_REG   = 2'b00,
    SRCB_ONE   = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

endpackage

// File: rtl/mips_controller_if.sv
// Control bundle between the FSM (master) and the 8-bit datapath (slave).
interface mips_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       alusrca;
  logic       memtoreg;
  logic       iord;
  logic       regwrite;
  logic       regdst;
  logic       pcen;
  logic [3:0] irwrite;
  logic [1:0] pcsource;
  logic [1:0] alusrcb;
  logic [2:0] alucont;

  modport master (
    input  op, funct, zero,
    output memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst,
           pcen, irwrite, pcsource, alusrcb, alucont
  );

  modport slave (
    output op, funct, zero,
    input  memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst,
           pcen, irwrite, pcsource, alusrcb, alucont
  );
endinterface

// File: rtl/mips_controller_alu_decoder.sv
// Maps the FSM's aluop plus the R-type funct field to the ALU control code.
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont
);

  always_comb begin
    alucont = ALUC_ADD;
    case (aluop)
      ALUOP_ADD: alucont = ALUC_ADD;
      ALUOP_SUB: alucont = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucont = ALUC_ADD;
          FUNCT_SUB: alucont = ALUC_SUB;
          FUNCT_AND: alucont = ALUC_AND;
          FUNCT_OR:  alucont = ALUC_OR;
          FUNCT_SLT: alucont = ALUC_SLT;
          default:   alucont = ALUC_ADD;
        endcase
      end
      default: alucont = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle Moore control FSM: byte-wise fetch, decode, and execute for
// LB/SB/RTYPE/BEQ/J/ADDI, driving all datapath enables and selects.
module mips_controller
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  mips_controller_if.master  ctl
);

  state_t   state, next_state;
  logic     pcwrite, branch;
  aluop_t   aluop;
  pcsrc_t   pcsource;
  alusrcb_t alusrcb;
  logic [2:0] alucont;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH1;
    else          state <= next_state;
  end

  always_comb begin
    next_state   = FETCH1;
    ctl.memread  = 1'b0;
    ctl.memwrite = 1'b0;
    ctl.alusrca  = 1'b0;
    ctl.memtoreg = 1'b0;
    ctl.iord     = 1'b0;
    ctl.regwrite = 1'b0;
    ctl.regdst   = 1'b0;
    ctl.irwrite  = '0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    pcsource     = PCSRC_ALU;
    alusrcb      = SRCB_REG;
    aluop        = ALUOP_ADD;
    case (state)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        ctl.memread = 1'b1;
        alusrcb     = SRCB_ONE;
        pcwrite     = 1'b1;
        // Low two state bits select the instruction-register byte lane.
        ctl.irwrite = 4'b0001 << state[1:0];
        next_state  = (state == FETCH4) ? DECODE : state_t'(state + 4'd1);
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (ctl.op)
          OP_LB, OP_SB: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_J:         next_state = JEX;
          OP_ADDI:      next_state = ADDIEX;
          default:      next_state = FETCH1;
        endcase
      end
      MEMADR: begin
        ctl.alusrca = 1'b1;
        alusrcb     = SRCB_IMM;
        next_state  = (ctl.op == OP_LB) ? LBRD : SBWR;
      end
      LBRD: begin
        ctl.memread = 1'b1;
        ctl.iord    = 1'b1;
        next_state  = LBWR;
      end
      LBWR: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
      end
      SBWR: begin
        ctl.memwrite = 1'b1;
        ctl.iord     = 1'b1;
      end
      RTYPEEX: begin
        ctl.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
        next_state  = RTYPEWR;
      end
      RTYPEWR: begin
        ctl.regdst   = 1'b1;
        ctl.regwrite = 1'b1;
      end
      BEQEX: begin
        ctl.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        branch      = 1'b1;
        pcsource    = PCSRC_ALUOUT;
      end
      JEX: begin
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
      end
      ADDIEX: begin
        ctl.alusrca = 1'b1;
        alusrcb     = SRCB_IMM;
        next_state  = ADDIWR;
      end
      ADDIWR: ctl.regwrite = 1'b1;
      default: next_state = FETCH1;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop   (aluop),
    .funct   (ctl.funct),
    .alucont (alucont)
  );

  assign ctl.alucont  = alucont;
  assign ctl.pcsource = pcsource;
  assign ctl.alusrcb  = alusrcb;
  assign ctl.pcen     = pcwrite | (branch & ctl.zero);

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: per-cycle expected control vectors are
// queued per instruction and checked against the DUT one cycle at a time.
module tb_mips_controller;

  logic clk;
  logic reset_n;

  mips_controller_if bus ();

  mips_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctl     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [18:0] v;
  } exp_t;

  exp_t        sbq[$];
  int unsigned compared;
  int unsigned mismatched;

  // {memread,memwrite,alusrca,memtoreg,iord,regwrite,regdst,pcen,
  //  irwrite[3:0],pcsource[1:0],alusrcb[1:0],alucont[2:0]}
  function automatic logic [18:0] mk(
    logic mr, logic mw, logic asa, logic mtr, logic iord, logic rw, logic rd,
    logic pcen, logic [3:0] ir, logic [1:0] ps, logic [1:0] asb, logic [2:0] ac);
    return {mr, mw, asa, mtr, iord, rw, rd, pcen, ir, ps, asb, ac};
  endfunction

  function automatic logic [18:0] obs();
    return {bus.memread, bus.memwrite, bus.alusrca, bus.memtoreg, bus.iord,
            bus.regwrite, bus.regdst, bus.pcen, bus.irwrite, bus.pcsource,
            bus.alusrcb, bus.alucont};
  endfunction

  function automatic logic [18:0] e_fetch(int unsigned n);
    logic [3:0] ir;
    ir = 4'b0001;
    ir = ir << (n - 1);
    return mk(1,0,0,0,0,0,0,1, ir, 2'b00, 2'b01, 3'b010);
  endfunction

  function automatic logic [18:0] e_decode();  return mk(0,0,0,0,0,0,0,0, 4'h0, 2'b00, 2'b11, 3'b010); endfunction
  function automatic logic [18:0] e_memadr();  return mk(0,0,1,0,0,0,0,0, 4'h0, 2'b00, 2'b10, 3'b010); endfunction
  function automatic logic [18:0] e_lbrd();    return mk(1,0,0,0,1,0,0,0, 4'h0, 2'b00, 2'b00, 3'b010); endfunction
  function automatic logic [18:0] e_lbwr();    return mk(0,0,0,1,0,1,0,0, 4'h0, 2'b00, 2'b00, 3'b010); endfunction
  function automatic logic [18:0] e_sbwr();    return mk(0,1,0,0,1,0,0,0, 4'h0, 2'b00, 2'b00, 3'b010); endfunction
  function automatic logic [18:0] e_rtex(logic [2:0] ac); return mk(0,0,1,0,0,0,0,0, 4'h0, 2'b00, 2'b00, ac); endfunction
  function automatic logic [18:0] e_rtwr();    return mk(0,0,0,0,0,1,1,0, 4'h0, 2'b00, 2'b00, 3'b010); endfunction
  function automatic logic [18:0] e_beqex(logic z); return mk(0,0,1,0,0,0,0,z, 4'h0, 2'b01, 2'b00, 3'b110); endfunction
  function automatic logic [18:0] e_jex();     return mk(0,0,0,0,0,0,0,1, 4'h0, 2'b10, 2'b00, 3'b010); endfunction
  function automatic logic [18:0] e_addiex();  return mk(0,0,1,0,0,0,0,0, 4'h0, 2'b00, 2'b10, 3'b010); endfunction
  function automatic logic [18:0] e_addiwr();  return mk(0,0,0,0,0,1,0,0, 4'h0, 2'b00, 2'b00, 3'b010); endfunction

  task automatic push(string tag, logic [18:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic check(string tag, logic [18:0] e);
    logic [18:0] o;
    o = obs();
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // One comparison per cycle, sampled 1 time unit after the falling edge.
  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      #1;
      check(e.tag, e.v);
      @(negedge clk);
    end
  endtask

  task automatic push_front_end(string name);
    for (int unsigned n = 1; n <= 4; n++)
      push($sformatf("%s_fetch%0d", name, n), e_fetch(n));
    push({name, "_decode"}, e_decode());
  endtask

  task automatic run_instr(string name, logic [5:0] op, logic [5:0] funct,
                           logic zero, logic [2:0] rt_ac);
    bus.op    = op;
    bus.funct = funct;
    bus.zero  = zero;
    push_front_end(name);
    case (op)
      6'b100000: begin
        push({name, "_memadr"}, e_memadr());
        push({name, "_lbrd"}, e_lbrd());
        push({name, "_lbwr"}, e_lbwr());
      end
      6'b101000: begin
        push({name, "_memadr"}, e_memadr());
        push({name, "_sbwr"}, e_sbwr());
      end
      6'b000000: begin
        push({name, "_rtypeex"}, e_rtex(rt_ac));
        push({name, "_rtypewr"}, e_rtwr());
      end
      6'b000100: push({name, "_beqex"}, e_beqex(zero));
      6'b000010: push({name, "_jex"}, e_jex());
      6'b001000: begin
        push({name, "_addiex"}, e_addiex());
        push({name, "_addiwr"}, e_addiwr());
      end
      default: ;
    endcase
    drain();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    bus.op     = 6'b111111;
    bus.funct  = 6'b000000;
    bus.zero   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", e_fetch(1));
    reset_n = 1'b1;

    run_instr("lb",      6'b100000, 6'b000000, 1'b0, 3'b010);
    run_instr("beq_z1",  6'b000100, 6'b000000, 1'b1, 3'b010);
    run_instr("beq_z0",  6'b000100, 6'b000000, 1'b0, 3'b010);
    run_instr("j",       6'b000010, 6'b000000, 1'b0, 3'b010);
    run_instr("r_add",   6'b000000, 6'b100000, 1'b0, 3'b010);
    run_instr("r_sub",   6'b000000, 6'b100010, 1'b0, 3'b110);
    run_instr("r_and",   6'b000000, 6'b100100, 1'b0, 3'b000);
    run_instr("r_or",    6'b000000, 6'b100101, 1'b0, 3'b001);
    run_instr("r_slt",   6'b000000, 6'b101010, 1'b0, 3'b111);
    run_instr("r_other", 6'b000000, 6'b000000, 1'b0, 3'b010);
    run_instr("addi",    6'b001000, 6'b000000, 1'b1, 3'b010);
    run_instr("sb",      6'b101000, 6'b000000, 1'b0, 3'b010);
    run_instr("unknown", 6'b111111, 6'b000000, 1'b0, 3'b010);

    // Abort an R-type in RTYPEEX with reset, then hold reset across an edge.
    bus.op    = 6'b000000;
    bus.funct = 6'b100010;
    bus.zero  = 1'b0;
    push_front_end("abort");
    drain();
    #1;
    check("abort_rtypeex", e_rtex(3'b110));
    reset_n = 1'b0;
    #1;
    check("reset_mid_instr", e_fetch(1));
    @(negedge clk);
    #1;
    check("reset_held", e_fetch(1));
    reset_n = 1'b1;

    run_instr("post_reset", 6'b000000, 6'b100101, 1'b0, 3'b001);
    #1;
    check("final_fetch1", e_fetch(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
